// File: rtl/turn_on_pkg.sv
// Shared types for the G-15 turn-on sequencer: state encoding, panel decode
// constants and the phase-selection helper.
package turn_on_pkg;

    typedef enum logic [2:0] {
        TON_IDLE   = 3'd0,
        TON_WARMUP = 3'd1,
        TON_SYNC   = 3'd2,
        TON_CLEAR  = 3'd3,
        TON_NT     = 3'd4,
        TON_ATS    = 3'd5,
        TON_RUN    = 3'd6,
        TON_FAULT  = 3'd7
    } ton_state_t;

    // Raw SEQ_STATE codes for the maintenance-panel display decoder
    localparam logic [2:0] SEQ_STATE_IDLE   = 3'd0;
    localparam logic [2:0] SEQ_STATE_WARMUP = 3'd1;
    localparam logic [2:0] SEQ_STATE_SYNC   = 3'd2;
    localparam logic [2:0] SEQ_STATE_CLEAR  = 3'd3;
    localparam logic [2:0] SEQ_STATE_NT     = 3'd4;
    localparam logic [2:0] SEQ_STATE_ATS    = 3'd5;
    localparam logic [2:0] SEQ_STATE_RUN    = 3'd6;
    localparam logic [2:0] SEQ_STATE_FAULT  = 3'd7;

    typedef struct packed {
        logic no_clear;
        logic no_nt;
        logic auto_load;
    } ton_sel_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // First enabled phase following 'from' (SYNC, CLEAR or NT), in CLEAR/NT/ATS order
    function automatic ton_state_t next_phase(input ton_state_t from, input ton_sel_t sel);
        ton_state_t nxt;
        nxt = TON_RUN;
        if (from == TON_SYNC && !sel.no_clear) begin
            nxt = TON_CLEAR;
        end else if ((from == TON_SYNC || from == TON_CLEAR) && !sel.no_nt) begin
            nxt = TON_NT;
        end else if (sel.auto_load) begin
            nxt = TON_ATS;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rev_counter.sv
// Loadable drum-revolution counter with terminal-count compare, shared by the
// CLEAR, NT and ATS phases.
module rev_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/turn_on_sequencer.sv
// G-15 turn-on sequencer: warm-up timing, drum alignment, optional clear / NT /
// ATS phases, then operate. Outputs are decoded from the state register.
module turn_on_sequencer
    import turn_on_pkg::*;
#(
    parameter int WARMUP_CYCLES    = 1000,
    parameter int CLR_REVS         = 2,
    parameter int NT_REVS          = 1,
    parameter int ATS_TIMEOUT_REVS = 64
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       PWR_ON_KEY,
    input  logic       PWR_OFF_KEY,
    input  logic       SEL_NO_CLEAR,
    input  logic       SEL_NO_NT,
    input  logic       SEL_AUTO_LOAD,
    input  logic       DRUM_REV,
    input  logic       TAPE_DONE,
    output logic       PWR_CLEAR,
    output logic       PWR_NO_CLEAR,
    output logic       PWR_NT,
    output logic       PWR_ATS,
    output logic       PWR_OP,
    output logic       PWR_NO_OP,
    output logic       SEQ_READY,
    output logic       SEQ_FAULT,
    output logic [2:0] SEQ_STATE
);

    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int RW = $clog2(max3(CLR_REVS, NT_REVS, ATS_TIMEOUT_REVS) + 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [RW-1:0] CLR_LAST  = RW'(CLR_REVS - 1);
    localparam logic [RW-1:0] NT_LAST   = RW'(NT_REVS - 1);
    localparam logic [RW-1:0] ATS_LAST  = RW'(ATS_TIMEOUT_REVS - 1);

    ton_state_t    state_q;
    ton_state_t    state_d;
    ton_sel_t      sel_q;
    ton_sel_t      sel_d;
    ton_sel_t      sel_in;
    logic          key_q;
    logic          key_rise;
    logic [WW-1:0] warm_q;
    logic [WW-1:0] warm_d;
    logic          rev_load;
    logic          rev_inc;
    logic          rev_tc;
    logic          rev_hit;
    logic [RW-1:0] rev_last;

    assign sel_in   = {SEL_NO_CLEAR, SEL_NO_NT, SEL_AUTO_LOAD};
    assign key_rise = PWR_ON_KEY & ~key_q;
    assign rev_hit  = DRUM_REV & rev_tc;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            TON_IDLE:   if (key_rise) state_d = TON_WARMUP;
            TON_WARMUP: if (warm_q == WARM_LAST) state_d = TON_SYNC;
            TON_SYNC: begin
                if (DRUM_REV) begin
                    sel_d   = sel_in;
                    state_d = next_phase(TON_SYNC, sel_in);
                end
            end
            TON_CLEAR:  if (rev_hit) state_d = next_phase(TON_CLEAR, sel_q);
            TON_NT:     if (rev_hit) state_d = next_phase(TON_NT, sel_q);
            TON_ATS: begin
                // A load finishing on the timeout revolution still counts as success
                if (TAPE_DONE) begin
                    state_d = TON_RUN;
                end else if (rev_hit) begin
                    state_d = TON_FAULT;
                end
            end
            TON_RUN:    state_d = TON_RUN;
            TON_FAULT:  if (key_rise) state_d = TON_WARMUP;
            default:    state_d = TON_IDLE;
        endcase
        if (PWR_OFF_KEY) begin
            state_d = TON_IDLE;
        end
    end

    always_comb begin
        warm_d = warm_q;
        if (state_d == TON_WARMUP && state_q != TON_WARMUP) begin
            warm_d = '0;
        end else if (state_q == TON_WARMUP) begin
            warm_d = warm_q + 1'b1;
        end
    end

    always_comb begin
        rev_last = '0;
        case (state_q)
            TON_CLEAR: rev_last = CLR_LAST;
            TON_NT:    rev_last = NT_LAST;
            TON_ATS:   rev_last = ATS_LAST;
            default:   rev_last = '0;
        endcase
    end

    // Reload on every state change so the entry revolution is never counted
    assign rev_load = (state_d != state_q);
    assign rev_inc  = DRUM_REV & (state_q == TON_CLEAR || state_q == TON_NT || state_q == TON_ATS);

    rev_counter #(.W(RW)) u_rev_counter (
        .clk    (CLOCK),
        .srst   (rst),
        .load_i (rev_load),
        .inc_i  (rev_inc),
        .last_i (rev_last),
        .tc_o   (rev_tc)
    );

    // key_q resets high so a key held through reset cannot start a sequence
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q <= TON_IDLE;
            sel_q   <= '0;
            key_q   <= 1'b1;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            key_q   <= PWR_ON_KEY;
            warm_q  <= warm_d;
        end
    end

    assign PWR_CLEAR    = (state_q == TON_CLEAR);
    assign PWR_NO_CLEAR = ~PWR_CLEAR;
    assign PWR_NT       = (state_q == TON_NT);
    assign PWR_ATS      = (state_q == TON_ATS);
    assign PWR_OP       = (state_q == TON_ATS) || (state_q == TON_RUN);
    assign PWR_NO_OP    = ~PWR_OP;
    assign SEQ_READY    = (state_q == TON_RUN);
    assign SEQ_FAULT    = (state_q == TON_FAULT);
    assign SEQ_STATE    = state_q;

endmodule

// File: tb/tb_turn_on_sequencer.sv
// Scoreboard bench for turn_on_sequencer: stimulus queues the expected state
// sequence, a monitor checks each state change (or probe) against it.
module tb_turn_on_sequencer;

    localparam int WARM = 10;
    localparam int CLR  = 2;
    localparam int NTR  = 1;
    localparam int ATO  = 3;
    localparam int REV  = 50;

    logic       CLOCK = 1'b0;
    logic       rst = 1'b1;
    logic       PWR_ON_KEY = 1'b1;
    logic       PWR_OFF_KEY = 1'b0;
    logic       SEL_NO_CLEAR = 1'b0;
    logic       SEL_NO_NT = 1'b0;
    logic       SEL_AUTO_LOAD = 1'b0;
    logic       DRUM_REV = 1'b0;
    logic       TAPE_DONE = 1'b0;
    logic       PWR_CLEAR, PWR_NO_CLEAR, PWR_NT, PWR_ATS, PWR_OP, PWR_NO_OP;
    logic       SEQ_READY, SEQ_FAULT;
    logic [2:0] SEQ_STATE;

    typedef struct {
        string      name;
        logic [2:0] st;
        int         dur;
        bit         drum;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   probe = 1'b0;

    turn_on_sequencer #(
        .WARMUP_CYCLES    (WARM),
        .CLR_REVS         (CLR),
        .NT_REVS          (NTR),
        .ATS_TIMEOUT_REVS (ATO)
    ) dut (
        .CLOCK         (CLOCK),
        .rst           (rst),
        .PWR_ON_KEY    (PWR_ON_KEY),
        .PWR_OFF_KEY   (PWR_OFF_KEY),
        .SEL_NO_CLEAR  (SEL_NO_CLEAR),
        .SEL_NO_NT     (SEL_NO_NT),
        .SEL_AUTO_LOAD (SEL_AUTO_LOAD),
        .DRUM_REV      (DRUM_REV),
        .TAPE_DONE     (TAPE_DONE),
        .PWR_CLEAR     (PWR_CLEAR),
        .PWR_NO_CLEAR  (PWR_NO_CLEAR),
        .PWR_NT        (PWR_NT),
        .PWR_ATS       (PWR_ATS),
        .PWR_OP        (PWR_OP),
        .PWR_NO_OP     (PWR_NO_OP),
        .SEQ_READY     (SEQ_READY),
        .SEQ_FAULT     (SEQ_FAULT),
        .SEQ_STATE     (SEQ_STATE)
    );

    always #5 CLOCK = ~CLOCK;

    // {CLEAR, NO_CLEAR, NT, ATS, OP, NO_OP, READY, FAULT} for a given state
    function automatic logic [7:0] model_out(input logic [2:0] s);
        logic clr, op;
        clr = (s == 3'd3);
        op  = (s == 3'd5) || (s == 3'd6);
        return {clr, ~clr, (s == 3'd4), (s == 3'd5), op, ~op, (s == 3'd6), (s == 3'd7)};
    endfunction

    // Monitor
    initial begin : monitor
        logic [2:0] prev;
        logic [7:0] act;
        int         run_len;
        bit         last_drum;
        bit         changed;
        exp_t       e;
        @(negedge CLOCK);
        prev      = SEQ_STATE;
        run_len   = 1;
        last_drum = DRUM_REV;
        forever begin
            @(negedge CLOCK);
            changed = (SEQ_STATE !== prev);
            if (changed || probe) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: state=%0d (from %0d) required no event", SEQ_STATE, prev);
                end else begin
                    e = sb_q.pop_front();
                    act = {PWR_CLEAR, PWR_NO_CLEAR, PWR_NT, PWR_ATS, PWR_OP, PWR_NO_OP, SEQ_READY, SEQ_FAULT};
                    n_cmp++;
                    if (SEQ_STATE !== e.st) begin
                        n_bad++;
                        $display("FAIL %s state: got %0d required %0d", e.name, SEQ_STATE, e.st);
                    end
                    n_cmp++;
                    if (act !== model_out(e.st)) begin
                        n_bad++;
                        $display("FAIL %s outputs: got %b required %b", e.name, act, model_out(e.st));
                    end
                    if (changed && e.dur >= 0) begin
                        n_cmp++;
                        if (run_len != e.dur) begin
                            n_bad++;
                            $display("FAIL %s prev_duration: got %0d required %0d", e.name, run_len, e.dur);
                        end
                    end
                    if (changed && e.drum) begin
                        n_cmp++;
                        if (!last_drum) begin
                            n_bad++;
                            $display("FAIL %s drum_aligned: got %0d required 1", e.name, last_drum);
                        end
                    end
                    $display("event %-16s state=%0d outs=%b prev_len=%0d cyc=%0d", e.name, SEQ_STATE, act, run_len, cyc);
                end
            end
            run_len   = changed ? 1 : run_len + 1;
            prev      = SEQ_STATE;
            last_drum = DRUM_REV;
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
        cyc++;
        DRUM_REV = (cyc % REV == 0);
    endtask

    task automatic expect_ev(input string nm, input logic [2:0] st, input int dur, input bit drum);
        exp_t e;
        e.name = nm;
        e.st   = st;
        e.dur  = dur;
        e.drum = drum;
        sb_q.push_back(e);
    endtask

    task automatic do_probe();
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic press();
        PWR_ON_KEY = 1'b1;
        tick();
        PWR_ON_KEY = 1'b0;
    endtask

    task automatic off_pulse();
        PWR_OFF_KEY = 1'b1;
        tick();
        PWR_OFF_KEY = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string nm);
        int n;
        n = 0;
        while (SEQ_STATE !== s && n < 600) begin
            tick();
            n++;
        end
        if (SEQ_STATE !== s) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s wait: got state %0d required %0d within 600 cycles", nm, SEQ_STATE, s);
        end
    endtask

    // Returns with the n-th DRUM_REV pulse active in the current cycle
    task automatic wait_drums(input int n, input string nm);
        int k, b;
        k = 0;
        b = 0;
        while (k < n && b < 400) begin
            tick();
            b++;
            if (DRUM_REV) k++;
        end
        if (k < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s drums: got %0d required %0d", nm, k, n);
        end
    endtask

    initial begin : stimulus
        // Key held through reset must not start a sequence
        repeat (3) tick();
        rst = 1'b0;
        tick();
        expect_ev("reset_idle", 3'd0, -1, 1'b0);
        do_probe();
        repeat (5) tick();
        expect_ev("key_held_idle", 3'd0, -1, 1'b0);
        do_probe();
        PWR_ON_KEY = 1'b0;
        tick();

        // Full sequence; SEL changes during CLEAR must be ignored
        {SEL_NO_CLEAR, SEL_NO_NT, SEL_AUTO_LOAD} = 3'b001;
        expect_ev("s1_warmup", 3'd1, -1, 1'b0);
        expect_ev("s1_sync", 3'd2, WARM, 1'b0);
        expect_ev("s1_clear", 3'd3, -1, 1'b1);
        expect_ev("s1_nt", 3'd4, CLR * REV, 1'b1);
        expect_ev("s1_ats", 3'd5, NTR * REV, 1'b1);
        expect_ev("s1_run", 3'd6, ATO * REV, 1'b1);
        press();
        wait_state(3'd3, "s1_clear");
        {SEL_NO_CLEAR, SEL_NO_NT, SEL_AUTO_LOAD} = 3'b110;
        wait_state(3'd5, "s1_ats");
        wait_drums(ATO, "s1_tape");
        TAPE_DONE = 1'b1;
        tick();
        TAPE_DONE = 1'b0;
        wait_state(3'd6, "s1_run");
        repeat (60) tick();
        expect_ev("s1_off", 3'd0, -1, 1'b0);
        off_pulse();
        tick();

        // All phases skipped: SYNC straight to RUN on the drum pulse
        {SEL_NO_CLEAR, SEL_NO_NT, SEL_AUTO_LOAD} = 3'b110;
        expect_ev("s2_warmup", 3'd1, -1, 1'b0);
        expect_ev("s2_sync", 3'd2, WARM, 1'b0);
        expect_ev("s2_run", 3'd6, -1, 1'b1);
        press();
        wait_state(3'd6, "s2_run");
        repeat (3) tick();
        expect_ev("s2_off", 3'd0, -1, 1'b0);
        off_pulse();
        tick();

        // ATS timeout to FAULT, then restart from FAULT
        {SEL_NO_CLEAR, SEL_NO_NT, SEL_AUTO_LOAD} = 3'b111;
        expect_ev("s3_warmup", 3'd1, -1, 1'b0);
        expect_ev("s3_sync", 3'd2, WARM, 1'b0);
        expect_ev("s3_ats", 3'd5, -1, 1'b1);
        expect_ev("s3_fault", 3'd7, ATO * REV, 1'b1);
        press();
        wait_state(3'd7, "s3_fault");
        repeat (5) tick();
        expect_ev("s3_rewarm", 3'd1, -1, 1'b0);
        press();
        repeat (3) tick();
        expect_ev("s3_off", 3'd0, -1, 1'b0);
        off_pulse();
        tick();

        // PWR_OFF_KEY on the terminal CLEAR revolution beats the move to NT
        {SEL_NO_CLEAR, SEL_NO_NT, SEL_AUTO_LOAD} = 3'b000;
        expect_ev("s4_warmup", 3'd1, -1, 1'b0);
        expect_ev("s4_sync", 3'd2, WARM, 1'b0);
        expect_ev("s4_clear", 3'd3, -1, 1'b1);
        expect_ev("s4_off_at_rev", 3'd0, -1, 1'b1);
        press();
        wait_state(3'd3, "s4_clear");
        wait_drums(CLR, "s4_rev");
        off_pulse();
        tick();
        expect_ev("s4_idle_hold", 3'd0, -1, 1'b0);
        do_probe();

        // Reset during NT
        {SEL_NO_CLEAR, SEL_NO_NT, SEL_AUTO_LOAD} = 3'b100;
        expect_ev("s5_warmup", 3'd1, -1, 1'b0);
        expect_ev("s5_sync", 3'd2, WARM, 1'b0);
        expect_ev("s5_nt", 3'd4, -1, 1'b1);
        expect_ev("s5_rst_idle", 3'd0, -1, 1'b0);
        press();
        wait_state(3'd4, "s5_nt");
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        expect_ev("s5_after_rst", 3'd0, -1, 1'b0);
        do_probe();
        repeat (3) tick();

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0 (next %s)", sb_q.size(), sb_q[0].name);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
